ps2_key_frontend: RTL and testbench

- Upstream input stage for the seven-segment display path.
- Receives raw PS/2 keyboard frames and validates them.
- Buffers the scan codes in a small FIFO and tracks the currently held key and the total key-press count.
- Its key_code and press_count outputs are intended to drive the hex display decoders directly. fifo_data serves a CPU-style consumer.

---
 rtl/ps2_key_frontend_if.sv | 25 ++
 rtl/ps2_key_frontend.sv | 202 ++++++++++++++++++++
 tb/tb_ps2_key_frontend.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_frontend_if.sv
// ps2_key_frontend_if
//   Consumer-side bus of the PS/2 key front end: the scan-code FIFO head,
//   its valid flag, the sticky overflow flag and the pop request.
//   master : the consumer (drives rd_en, observes the FIFO head)
//   slave  : the front end (serves the FIFO head, accepts rd_en)
interface ps2_key_frontend_if;
  logic       rd_en;
  logic [7:0] fifo_data;
  logic       fifo_valid;
  logic       overflow;

  modport master (
    output rd_en,
    input  fifo_data,
    input  fifo_valid,
    input  overflow
  );

  modport slave (
    input  rd_en,
    output fifo_data,
    output fifo_valid,
    output overflow
  );
endinterface

// File: rtl/ps2_key_frontend.sv
// ps2_key_frontend
//   Receives raw PS/2 keyboard frames, validates them, buffers good scan
//   codes in a small FIFO and tracks the held key plus a press counter that
//   feed the hex display decoders.
//
//   Optional build macro: PS2_PARITY_CHECK_EN
//     defined   - frames failing odd parity over data+parity are rejected
//     undefined - the parity bit is ignored (start/stop still checked)
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-low reset (0 = reset)
//   ps2_clk     PS/2 clock, asynchronous to clk
//   ps2_data    PS/2 data, asynchronous to clk
//   bus         slave side of ps2_key_frontend_if (rd_en, fifo_data,
//               fifo_valid, overflow)
//   frame_err   one-cycle pulse on a rejected or timed-out frame
//   key_code    make code of the most recently pressed key
//   key_down    key_code is currently held
//   press_count number of distinct key presses, modulo 256
module ps2_key_frontend #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ps2_clk,
  input  logic                     ps2_data,
  ps2_key_frontend_if.slave        bus,
  output logic                     frame_err,
  output logic [7:0]               key_code,
  output logic                     key_down,
  output logic [7:0]               press_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {
    ST_IDLE,
    ST_BREAK
  } trk_state_e;

  logic [2:0]    ps2c_sync_q, ps2c_sync_d;
  logic [1:0]    ps2d_sync_q, ps2d_sync_d;
  logic          fall;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    shift_q, shift_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          frame_err_q, frame_err_d;
  logic          par_ok;
  logic          good_frame;
  logic [7:0]    rx_code;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          overflow_q, overflow_d;
  logic          empty, full, do_push, do_pop;

  trk_state_e    state_q;
  logic [7:0]    key_code_q;
  logic          key_down_q;
  logic [7:0]    press_count_q;

  function automatic logic frame_ok(input logic start_bit, input logic stop_bit,
                                    input logic parity_good);
    return ~start_bit & stop_bit & parity_good;
  endfunction

`ifdef PS2_PARITY_CHECK_EN
  assign par_ok = ^shift_q[9:1];
`else
  assign par_ok = 1'b1;
`endif

  // ---- synchroniser / edge detect
  always_comb begin
    ps2c_sync_d = {ps2c_sync_q[1:0], ps2_clk};
    ps2d_sync_d = {ps2d_sync_q[0], ps2_data};
    fall        = ps2c_sync_q[2] & ~ps2c_sync_q[1];
  end

  // ---- frame receiver and timeout
  // Bits shift in from the top, so after ten edges shift_q[0] holds the start
  // bit, [8:1] the data byte and [9] parity; the stop bit is taken live.
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    to_cnt_d    = to_cnt_q;
    frame_err_d = 1'b0;
    good_frame  = 1'b0;
    rx_code     = shift_q[8:1];
    if (fall) begin
      to_cnt_d = '0;
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = '0;
        if (frame_ok(shift_q[0], ps2d_sync_q[1], par_ok)) begin
          good_frame = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        shift_d   = {ps2d_sync_q[1], shift_q[9:1]};
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        bit_cnt_d   = '0;
        to_cnt_d    = '0;
        frame_err_d = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  // ---- scan-code FIFO
  // A full FIFO still accepts a push when the same cycle pops the head.
  always_comb begin
    empty      = (wr_ptr_q == rd_ptr_q);
    full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop     = bus.rd_en & ~empty;
    do_push    = good_frame & (~full | do_pop);
    wr_ptr_d   = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d   = rd_ptr_q + (AW+1)'(do_pop);
    overflow_d = overflow_q | (good_frame & full & ~do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ps2c_sync_q <= 3'b111;
      ps2d_sync_q <= 2'b11;
      bit_cnt_q   <= '0;
      to_cnt_q    <= '0;
      frame_err_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
    end else begin
      ps2c_sync_q <= ps2c_sync_d;
      ps2d_sync_q <= ps2d_sync_d;
      bit_cnt_q   <= bit_cnt_d;
      to_cnt_q    <= to_cnt_d;
      frame_err_q <= frame_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= rx_code;
    end
  end

  // ---- key tracker
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      key_code_q    <= 8'h00;
      key_down_q    <= 1'b0;
      press_count_q <= 8'h00;
    end else if (good_frame) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_code == 8'hF0) begin
            state_q <= ST_BREAK;
          end else if (rx_code != 8'hE0 &&
                       !(key_down_q && rx_code == key_code_q)) begin
            key_code_q    <= rx_code;
            key_down_q    <= 1'b1;
            press_count_q <= press_count_q + 8'd1;
          end
        end
        ST_BREAK: begin
          if (rx_code != 8'hE0) begin
            if (rx_code == key_code_q) begin
              key_down_q <= 1'b0;
            end
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.fifo_data  = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
  assign bus.fifo_valid = ~empty;
  assign bus.overflow   = overflow_q;
  assign frame_err      = frame_err_q;
  assign key_code       = key_code_q;
  assign key_down       = key_down_q;
  assign press_count    = press_count_q;

endmodule

// File: tb/tb_ps2_key_frontend.sv
// tb_ps2_key_frontend
//   Directed bench for ps2_key_frontend: reset state, single frame, typematic
//   and break sequence, FIFO overflow and drain, parity handling (follows
//   PS2_PARITY_CHECK_EN), mid-frame timeout, press counter wrap and reset
//   in the middle of a frame.
`timescale 1ns/1ps
module tb_ps2_key_frontend;
  localparam int DEPTH = 8;
  localparam int TMO   = 300;
  localparam int H     = 2;   // clk cycles per PS/2 clock half period

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic       frame_err;
  logic [7:0] key_code;
  logic       key_down;
  logic [7:0] press_count;

  int checks   = 0;
  int failures = 0;
  int err_cycles = 0;

  ps2_key_frontend_if bus();

  ps2_key_frontend #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .bus         (bus),
    .frame_err   (frame_err),
    .key_code    (key_code),
    .key_down    (key_down),
    .press_count (press_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err === 1'b1) err_cycles <= err_cycles + 1;
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Sends the first nbits of an 11-bit frame; bad_par inverts the parity bit.
  task automatic send_bits(input logic [7:0] code, input bit bad_par, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~(^code)) ^ bad_par, code, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      repeat (H) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (H) @(negedge clk);
      ps2_clk = 1'b1;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] code);
    send_bits(code, 1'b0, 11);
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk_eq(tag, bus.fifo_data, exp);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int err0;
    logic [7:0] exp_cnt;
    logic [7:0] exp_key;
    logic [7:0] c;

    rst = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    bus.rd_en = 1'b0;
    repeat (4) @(negedge clk);

    chk_eq("rst_fifo_valid", bus.fifo_valid, 1'b0);
    chk_eq("rst_fifo_data", bus.fifo_data, 8'h00);
    chk_eq("rst_overflow", bus.overflow, 1'b0);
    chk_eq("rst_frame_err", frame_err, 1'b0);
    chk_eq("rst_key_code", key_code, 8'h00);
    chk_eq("rst_key_down", key_down, 1'b0);
    chk_eq("rst_press_count", press_count, 8'h00);
    rst = 1'b1;
    @(negedge clk);

    // single make code
    send(8'h1C);
    chk_eq("f1_valid", bus.fifo_valid, 1'b1);
    chk_eq("f1_data", bus.fifo_data, 8'h1C);
    chk_eq("f1_key_code", key_code, 8'h1C);
    chk_eq("f1_key_down", key_down, 1'b1);
    chk_eq("f1_count", press_count, 8'h01);
    pop_chk("f1_pop", 8'h1C);
    chk_eq("f1_empty", bus.fifo_valid, 1'b0);

    // typematic repeat then break
    send(8'h1C);
    send(8'h1C);
    chk_eq("typ_count", press_count, 8'h01);
    send(8'hF0);
    send(8'h1C);
    chk_eq("brk_count", press_count, 8'h01);
    chk_eq("brk_key_down", key_down, 1'b0);
    chk_eq("brk_key_code", key_code, 8'h1C);
    pop_chk("seq_pop0", 8'h1C);
    pop_chk("seq_pop1", 8'h1C);
    pop_chk("seq_pop2", 8'hF0);
    pop_chk("seq_pop3", 8'h1C);
    chk_eq("seq_empty", bus.fifo_valid, 1'b0);
    chk_eq("seq_empty_data", bus.fifo_data, 8'h00);

    // overflow: nine frames into an eight-entry FIFO
    for (int i = 0; i < 9; i++) send(8'h21 + 8'(i));
    chk_eq("ovf_flag", bus.overflow, 1'b1);
    chk_eq("ovf_count", press_count, 8'd10);
    for (int i = 0; i < 8; i++) pop_chk("ovf_pop", 8'h21 + 8'(i));
    chk_eq("ovf_drained", bus.fifo_valid, 1'b0);
    chk_eq("ovf_sticky", bus.overflow, 1'b1);

    // parity-flipped frame
    err0 = err_cycles;
    send_bits(8'h2A, 1'b1, 11);
`ifdef PS2_PARITY_CHECK_EN
    chk_eq("par_err", err_cycles - err0, 1);
    chk_eq("par_fifo", bus.fifo_valid, 1'b0);
    chk_eq("par_key_code", key_code, 8'h29);
    chk_eq("par_count", press_count, 8'd10);
    exp_cnt = 8'd10;
`else
    chk_eq("par_err", err_cycles - err0, 0);
    chk_eq("par_fifo", bus.fifo_valid, 1'b1);
    chk_eq("par_key_code", key_code, 8'h2A);
    chk_eq("par_count", press_count, 8'd11);
    pop_chk("par_pop", 8'h2A);
    exp_cnt = 8'd11;
`endif

    // mid-frame timeout, then a clean frame
    err0 = err_cycles;
    send_bits(8'h45, 1'b0, 5);
    repeat (TMO + 40) @(negedge clk);
    chk_eq("tmo_err", err_cycles - err0, 1);
    chk_eq("tmo_fifo", bus.fifo_valid, 1'b0);
    send(8'h45);
    chk_eq("tmo_after_data", bus.fifo_data, 8'h45);
    chk_eq("tmo_after_key", key_code, 8'h45);
    chk_eq("tmo_after_count", press_count, exp_cnt + 8'd1);
    chk_eq("tmo_after_err", err_cycles - err0, 1);

    // press counter wrap
    do_reset();
    exp_key = 8'h00;
    for (int i = 0; i < 256; i++) begin
      c = 8'h01 + 8'(i % 127);
      send(c);
      send(8'hF0);
      send(c);
      exp_key = c;
      if (i == 254) begin
        chk_eq("wrap_ff", press_count, 8'hFF);
        chk_eq("wrap_ff_up", key_down, 1'b0);
      end
    end
    chk_eq("wrap_00", press_count, 8'h00);
    chk_eq("wrap_key", key_code, exp_key);

    // reset in the middle of a frame
    send_bits(8'h77, 1'b0, 6);
    rst = 1'b0;
    @(negedge clk);
    chk_eq("mid_rst_valid", bus.fifo_valid, 1'b0);
    chk_eq("mid_rst_ovf", bus.overflow, 1'b0);
    chk_eq("mid_rst_key", key_code, 8'h00);
    chk_eq("mid_rst_down", key_down, 1'b0);
    chk_eq("mid_rst_count", press_count, 8'h00);
    chk_eq("mid_rst_err", frame_err, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    err0 = err_cycles;
    send(8'h16);
    chk_eq("post_rst_data", bus.fifo_data, 8'h16);
    chk_eq("post_rst_key", key_code, 8'h16);
    chk_eq("post_rst_count", press_count, 8'h01);
    chk_eq("post_rst_err", err_cycles - err0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
